// File: rtl/nwc_pkg.sv
// Shared constants and state encoding for the NWC loader/processor pair.
package nwc_pkg;

  localparam int DATA_W = 60;
  localparam int LOG_N  = 12;
  localparam int N      = 1 << LOG_N;
  localparam logic [59:0] MOD_Q = 60'hFFFFFFFFFFC0001;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FIRE   = 2'd2,
    RUN    = 2'd3
  } state_t;

endpackage

// File: rtl/nwc_coef_buffer.sv
// N x DATA_W simple dual-port RAM, synchronous read, holds polynomial A.
module nwc_coef_buffer #(
  parameter int DATA_W = 60,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [(1 << ADDR_W)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register only advances on a read so it can drive the processor directly and hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nwc_input_loader.sv
// Streams A then B, pairs A[i]/B[i] to the processor, fires start, waits for results.
// Optional range check on input coefficients: define NWC_LOADER_RANGE_CHECK_EN.
//
// state  | meaning
// LOAD_A | accepting A[0..N-1] into the buffer
// LOAD_B | accepting B[i], emitting (A[i], B[i]) pairs
// FIRE   | final pair on the bus; start pulses next cycle
// RUN    | input blocked until output_active rises then falls
module nwc_input_loader
  import nwc_pkg::*;
#(
  parameter int DATA_W = nwc_pkg::DATA_W,
  parameter int LOG_N  = nwc_pkg::LOG_N,
  parameter logic [DATA_W-1:0] MOD_Q = nwc_pkg::MOD_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_in0,
  output logic [DATA_W-1:0] data_in1,
  output logic              write_enable,
  output logic              start,
  input  logic              output_active,
  output logic              busy,
  output logic              frame_err,
  output logic              range_err
);

  localparam int N = 1 << LOG_N;
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [LOG_N-1:0] cnt;
  logic             accept;
  logic             cnt_last;
  logic             frame_hit;
  logic             seen_rise;

  assign s_ready   = (state == LOAD_A) || (state == LOAD_B);
  assign accept    = s_valid && s_ready;
  assign cnt_last  = (cnt == LAST);
  assign frame_hit = accept && (s_last != cnt_last);
  assign busy      = !((state == LOAD_A) && (cnt == '0));

  nwc_coef_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG_N)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && (state == LOAD_A)),
    .wr_addr (cnt),
    .wr_data (s_data),
    .rd_en   (accept && (state == LOAD_B)),
    .rd_addr (cnt),
    .rd_data (data_in0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A: if (accept && cnt_last) state_next = LOAD_B;
      LOAD_B: if (accept && cnt_last) state_next = FIRE;
      FIRE:   state_next = RUN;
      RUN:    if (seen_rise && !output_active) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  // cnt wraps to 0 on the last beat of each polynomial, so FIRE/RUN always see cnt == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      data_in1     <= '0;
      write_enable <= 1'b0;
      start        <= 1'b0;
      seen_rise    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + 1'b1;
      if (accept && (state == LOAD_B)) data_in1 <= s_data;
      write_enable <= accept && (state == LOAD_B);
      start        <= (state == FIRE);
      seen_rise    <= (state == RUN) && (state_next == RUN) && (seen_rise || output_active);
      frame_err    <= frame_hit || (frame_err && !err_clr);
    end
  end

`ifdef NWC_LOADER_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) range_err <= 1'b0;
    else     range_err <= (accept && (s_data >= MOD_Q)) || (range_err && !err_clr);
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: doc/nwc_input_loader.md
Name: nwc_input_loader

Overview:
- Upstream feeder for nwc_top/nwc_processor.
- Accepts both input polynomials as one valid/ready coefficient stream: A[0..N-1] first, then B[0..N-1].
- Buffers A internally. As each B[i] arrives it is paired with A[i] and driven onto data_in0/data_in1 with write_enable.
- After the last pair it pulses start, then blocks new input until the processor's result stream (output_active) has completed.

Parameters:
- DATA_W, 60, coefficient width; must match the nwc_processor port width.
- LOG_N, 12, log2 of polynomial length.
- N, 2**LOG_N, coefficients per polynomial (derived; do not override).
- MOD_Q, 60'hFFFFFFFFFFC0001, modulus shared with nwc_processor; used only by the optional range check.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  DATA_W  input coefficient.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader can accept a beat; transfer = s_valid & s_ready at a rising edge.
- s_last  in  1  marks the final coefficient of each polynomial.
- err_clr  in  1  synchronous clear of the sticky error flags.
- data_in0  out  DATA_W  A[i] to the processor.
- data_in1  out  DATA_W  B[i] to the processor.
- write_enable  out  1  one pair written per high cycle.
- start  out  1  single-cycle start pulse.
- output_active  in  1  from the processor; high while results stream out.
- busy  out  1  a transaction is in progress.
- frame_err  out  1  sticky; s_last mismatch.
- range_err  out  1  sticky; coefficient >= MOD_Q (see Optional Feature).

Behaviour:
- Reset (async, active-high): state=LOAD_A, cnt=0, s_ready=1. data_in0/1=0; write_enable, start, busy, frame_err, range_err all 0. A partially loaded transaction is discarded; the processor is not notified.
- States:
  - LOAD_A: s_ready=1. Each accepted beat writes A[cnt] into the buffer and increments cnt. On accepting beat cnt==N-1: cnt=0, go to LOAD_B.
  - LOAD_B: s_ready=1. Each accepted beat with value b at edge k gives, during cycle k+1 (registered, 1-cycle latency): data_in0=A[cnt], data_in1=b, write_enable=1. A[cnt] is prefetched so no stall is ever inserted. A cycle with no accepted beat gives write_enable=0 (gaps allowed; the processor advances its address only on write_enable). On accepting beat cnt==N-1: go to FIRE.
  - FIRE: s_ready=0. Entered on the cycle carrying the final write_enable; start=1 in the following cycle only, then go to RUN.
  - RUN: s_ready=0. Wait for an output_active rising edge, then its falling edge; then go to LOAD_A with cnt=0. If output_active is already high on entry, that counts as the rise.
- busy=1 unless (state==LOAD_A && cnt==0).
- Counting is authoritative. s_last high on a beat other than N-1, or low on beat N-1, sets frame_err. The beat is still consumed normally.
- err_clr clears frame_err and range_err. If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- write_enable and start are never high in the same cycle.
- data_in0/1 hold their last values when write_enable=0.

Optional Feature:
- Macro: NWC_LOADER_RANGE_CHECK_EN.
- Defined: every accepted beat (A and B) is compared against MOD_Q; s_data >= MOD_Q sets range_err. Data is passed through unmodified.
- Undefined: no comparator is built and range_err is tied to 0. The port is always present.

Decomposition:
- Shared package/include nwc_pkg: DATA_W, LOG_N, N, MOD_Q, and the state encoding localparams (LOAD_A, LOAD_B, FIRE, RUN), shared with nwc_processor.
- One sub-module: nwc_coef_buffer, an N x DATA_W simple dual-port RAM with synchronous read (one write port, one read port), suitable for BRAM inference.

Test Plan (LOG_N=3, N=8):
- Reset then 16 back-to-back beats, A=1..8, B=101..108, s_last on beats 8 and 16 -> write_enable high for 8 consecutive cycles with pairs (1,101)..(8,108); first pair one cycle after the B[0] edge; start high exactly once, one cycle after the last write; frame_err=0.
- Same stream with s_valid low every other B beat -> write_enable toggles, still 8 pairs, identical values; start once.
- In RUN, s_valid=1 is held -> s_ready=0 and no beats consumed until output_active goes 1 then 0; s_ready=1 on the following cycle; busy falls to 0.
- s_last asserted on beat 5 of A -> frame_err=1, loading continues, 8 pairs still emitted. err_clr pulse -> frame_err=0.
- Assert rst after 3 B beats -> all outputs 0 immediately, s_ready=1. New full 16-beat stream -> correct 8 pairs, no residue from the aborted load.
- With NWC_LOADER_RANGE_CHECK_EN defined, send A[2]=MOD_Q -> range_err=1 and pair 2 carries MOD_Q unchanged. Without the macro -> range_err stays 0.
